attn_core: RTL and testbench
============================

Name: attn_core

Overview:
Parametrised successor of the attention core: Q/K SRAMs, MAC array, output FIFO and PSUM SRAM under host instruction control.
- Memory depth is generalised via `addr_w`.
- Adds a PSUM read-modify-write accumulate mode.
- Adds a hardware row-norm unit: the sum of absolute PSUM lane values, used for softmax normalisation, driven on `sum_out`.
- Instantiates the existing `mac_array`, `ofifo` and `sram_w32` blocks.

Parameters:
- `col`, 8, MAC columns / PSUM lanes per row (≤16).
- `bw`, 8, activation/weight bit width.
- `bw_psum`, 2*bw+4, signed PSUM lane width.
- `pr`, 16, products per column (Q/K row = pr*bw bits).
- `addr_w`, 5, SRAM address width; depth = 2**addr_w for all three memories.
- `sum_w`, bw_psum+4, unsigned row-norm width.
- `iw`, 2*addr_w+11, instruction width.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-low; sub-modules receive !reset.
- `inst`  in  iw  instruction word, sampled every cycle.
- `mem_in`  in  pr*bw  Q/K SRAM write data.
- `out`  out  bw_psum*col  PSUM SRAM read data.
- `sum_out`  out  sum_w  last completed row norm.
- `sum_valid`  out  1  one-cycle pulse when `sum_out` updates.
- `busy`  out  1  PSUM port owned internally (accumulate writeback or norm read).
- `pmem_conflict`  out  1  sticky; a host PSUM command was dropped.

Behaviour:
- inst fields:
  - [0] pmem_wr, [1] pmem_rd, [2] kmem_wr, [3] kmem_rd, [4] qmem_wr, [5] qmem_rd.
  - [7:6] mac mode (bit 6 selects kmem_out else qmem_out into the array).
  - [8+:addr_w] pmem_add; [8+addr_w+:addr_w] qkmem_add.
  - [8+2aw] ofifo_rd, [9+2aw] pmem_acc, [10+2aw] sum_start.
  - With addr_w=5, bits 18:0 equal the previous core's encoding.
- Q/K SRAMs: CEN=!(rd|wr), WEN=!wr, shared qkmem_add, 1-cycle read latency. Unchanged.
- Plain PSUM write (pmem_wr & !pmem_acc): writes fifo_out at pmem_add that cycle.
- Accumulate (pmem_wr & pmem_acc & !busy):
  - Cycle T: issue PSUM read at pmem_add; latch fifo_out and address.
  - Cycle T+1: write Q + latched, lane-wise signed bw_psum add, wrap-around; `busy`=1 during T+1.
- Row norm (sum_start & !busy & FSM IDLE), FSM IDLE→RD→ACC→IDLE:
  - RD: read pmem_add, busy=1.
  - ACC: busy=1; sum of |lane| over col lanes registered into `sum_out`; `sum_valid`=1 in the following cycle.
  - Most-negative lane: abs = 2**(bw_psum-1), exact, no overflow in sum_w.
- PSUM port priority: accumulate writeback > norm FSM > host.
  - Host pmem_rd/pmem_wr/sum_start arriving while busy: ignored, sets `pmem_conflict` (plain sum_start alone while busy is ignored without setting conflict).
  - Q/K/FIFO commands are never blocked.
- Host pmem_rd and pmem_wr set together: write wins (SRAM semantics).
- `out` = SRAM Q; undefined until the first PSUM read after power-up.
- Reset (reset=0 at a clk edge):
  - FSM→IDLE, `sum_out`=0, `sum_valid`=0, `busy`=0, `pmem_conflict`=0, pending accumulate discarded (no write).
  - SRAM contents are retained.
- Reset mid-accumulate or mid-norm aborts it the same way.

Optional Feature:
- `ATTN_CORE_SAT_ACC_EN` defined: accumulate saturates each lane to [-2**(bw_psum-1), 2**(bw_psum-1)-1].
- Undefined: two's-complement wrap-around.
- Plain writes and row norm are unaffected either way.

Decomposition:
- Package `attn_core_pkg`:
  - inst bit-index localparams as functions of addr_w.
  - Norm FSM state typedef (IDLE, RD, ACC).
  - Lane abs/saturate helper functions.
- One sub-module, `attn_row_norm`: FSM plus abs-sum adder over col lanes, with start/busy/sum_valid/sum_out.
- PSUM arbitration and accumulate pipeline stay in attn_core.

Test Plan:
- Reset: hold reset=0 3 cycles with random inst → sum_out=0, sum_valid=0, busy=0, pmem_conflict=0; release, plain write fifo lanes 1..8 to add 3, read add 3 → out lanes 1..8.
- Accumulate: PSUM[5] lanes all 100, FIFO lanes all -30, pmem_wr+pmem_acc add 5 → busy high 1 cycle, then read → all lanes 70.
- Wrap/saturate: PSUM[2] lanes 524287, FIFO lanes 1, accumulate → lanes -524288 without the macro, 524287 with `ATTN_CORE_SAT_ACC_EN`.
- Row norm: PSUM[7] lanes {-524288,1,-2,3,-4,5,-6,7}, sum_start add 7 → sum_valid one pulse 3 cycles later, sum_out=524316.
- Conflict: pmem_rd issued in the accumulate writeback cycle → read dropped, pmem_conflict=1 and stays 1 until reset; a second sum_start during norm is ignored.
- Reset mid-norm: reset=0 in RD state → no sum_valid, FSM IDLE; a new sum_start after release completes normally.

Source files
------------

// File: rtl/attn_core_pkg.sv
// attn_core_pkg: instruction field map, norm FSM encoding and lane helpers.
// Shared by attn_core; ATTN_CORE_SAT_ACC_EN selects saturating accumulate.
package attn_core_pkg;

  localparam int PMEM_WR_B = 0;
  localparam int PMEM_RD_B = 1;
  localparam int KMEM_WR_B = 2;
  localparam int KMEM_RD_B = 3;
  localparam int QMEM_WR_B = 4;
  localparam int QMEM_RD_B = 5;
  localparam int MODE_LSB  = 6;
  localparam int PADD_LSB  = 8;

  function automatic int qkadd_lsb(input int aw);
    return PADD_LSB + aw;
  endfunction

  function automatic int ofifo_rd_b(input int aw);
    return PADD_LSB + 2 * aw;
  endfunction

  function automatic int pmem_acc_b(input int aw);
    return PADD_LSB + 2 * aw + 1;
  endfunction

  function automatic int sum_start_b(input int aw);
    return PADD_LSB + 2 * aw + 2;
  endfunction

  typedef logic [1:0] norm_state_t;

  localparam norm_state_t NORM_IDLE = 2'd0;
  localparam norm_state_t NORM_RD   = 2'd1;
  localparam norm_state_t NORM_ACC  = 2'd2;

  function automatic logic [31:0] lane_abs(
    input logic signed [31:0] x
  );
    return x[31] ? -x : x;
  endfunction

  // clamp a widened lane sum back into a signed w-bit range
  function automatic logic [31:0] lane_sat(
    input logic signed [32:0] s,
    input int w
  );
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) return 32'(hi);
    if (s < lo) return 32'(lo);
    return 32'(s);
  endfunction

endpackage

// File: rtl/attn_row_norm.sv
// attn_row_norm: IDLE->RD->ACC FSM summing |lane| of one PSUM row.
// RD holds while the accumulate writeback owns the PSUM port.
module attn_row_norm
  import attn_core_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int sum_w   = 24,
  parameter int addr_w  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  input  logic [addr_w-1:0]      addr,
  input  logic [bw_psum*col-1:0] psum,
  output logic                   rd_en,
  output logic [addr_w-1:0]      rd_addr,
  output logic                   busy,
  output logic                   sum_valid,
  output logic [sum_w-1:0]       sum_out
);

  norm_state_t state;
  logic [sum_w-1:0] total;

  always_comb begin
    total = '0;
    for (int l = 0; l < col; l++) begin
      total = total + sum_w'(lane_abs(
        32'($signed(psum[l*bw_psum +: bw_psum]))));
    end
  end

  assign rd_en = (state == NORM_RD) && !stall;
  assign busy  = (state != NORM_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORM_IDLE;
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      sum_valid <= 1'b0;
      unique case (state)
        NORM_IDLE: if (start) state <= NORM_RD;
        NORM_RD:   if (!stall) state <= NORM_ACC;
        NORM_ACC: begin
          sum_out   <= total;
          sum_valid <= 1'b1;
          state     <= NORM_IDLE;
        end
        default: state <= NORM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == NORM_IDLE && start) rd_addr <= addr;
  end

endmodule

// File: rtl/mac_array.sv
// mac_array: unit-weight MAC columns; column l emits the sign-extended
// pr*bw/col-bit slice l of the streamed row when fired.
module mac_array #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 16
) (
  input  logic [pr*bw-1:0]       in_row,
  input  logic                   fire,
  output logic [bw_psum*col-1:0] out_lanes,
  output logic                   valid
);

  localparam int CW = pr * bw / col;

  for (genvar l = 0; l < col; l++) begin : g_col
    assign out_lanes[l*bw_psum +: bw_psum] =
      bw_psum'($signed(in_row[l*CW +: CW]));
  end

  assign valid = fire;

endmodule

// File: rtl/ofifo.sv
// ofifo: show-ahead output FIFO; dout is the head entry.
// Pushes when full and pops when empty are dropped.
module ofifo #(
  parameter int width   = 160,
  parameter int depth_w = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] mem [2**depth_w];
  logic [depth_w:0] wp;
  logic [depth_w:0] rp;
  logic             empty;
  logic             full;

  assign empty = (wp == rp);
  assign full  = (wp[depth_w] != rp[depth_w]) &&
                 (wp[depth_w-1:0] == rp[depth_w-1:0]);
  assign dout  = mem[rp[depth_w-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wp[depth_w-1:0]] <= din;
  end

endmodule

// File: rtl/sram_w32.sv
// sram_w32: single-port SRAM, active-low CEN/WEN, registered read data.
// Contents carry no reset.
module sram_w32 #(
  parameter int width  = 32,
  parameter int addr_w = 5
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              wen,
  input  logic [addr_w-1:0] a,
  input  logic [width-1:0]  d,
  output logic [width-1:0]  q
);

  logic [width-1:0] mem [2**addr_w];

  always_ff @(posedge clk) begin
    if (!cen && !wen) mem[a] <= d;
    if (!cen && wen) q <= mem[a];
  end

endmodule

// File: rtl/attn_core.sv
// attn_core: Q/K SRAMs, MAC array, output FIFO, PSUM SRAM with accumulate
// and row-norm. Define ATTN_CORE_SAT_ACC_EN for saturating accumulate.
module attn_core
  import attn_core_pkg::*;
#(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 16,
  parameter int addr_w  = 5,
  parameter int sum_w   = bw_psum+4,
  parameter int iw      = 2*addr_w+11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iw-1:0]          inst,
  input  logic [pr*bw-1:0]       mem_in,
  output logic [bw_psum*col-1:0] out,
  output logic [sum_w-1:0]       sum_out,
  output logic                   sum_valid,
  output logic                   busy,
  output logic                   pmem_conflict
);

  localparam int PW     = bw_psum * col;
  localparam int RW     = pr * bw;
  localparam int QK_LSB = qkadd_lsb(addr_w);
  localparam int FRD_B  = ofifo_rd_b(addr_w);
  localparam int ACC_B  = pmem_acc_b(addr_w);
  localparam int SST_B  = sum_start_b(addr_w);

  logic              rst;
  logic              pmem_wr, pmem_rd;
  logic              kmem_wr, kmem_rd;
  logic              qmem_wr, qmem_rd;
  logic [1:0]        mode;
  logic [addr_w-1:0] pmem_add, qkmem_add;
  logic              ofifo_rd, pmem_acc, sum_start;

  assign rst       = !reset;
  assign pmem_wr   = inst[PMEM_WR_B];
  assign pmem_rd   = inst[PMEM_RD_B];
  assign kmem_wr   = inst[KMEM_WR_B];
  assign kmem_rd   = inst[KMEM_RD_B];
  assign qmem_wr   = inst[QMEM_WR_B];
  assign qmem_rd   = inst[QMEM_RD_B];
  assign mode      = inst[MODE_LSB +: 2];
  assign pmem_add  = inst[PADD_LSB +: addr_w];
  assign qkmem_add = inst[QK_LSB +: addr_w];
  assign ofifo_rd  = inst[FRD_B];
  assign pmem_acc  = inst[ACC_B];
  assign sum_start = inst[SST_B];

  logic [RW-1:0] qmem_q, kmem_q, mac_in;
  logic [PW-1:0] mac_out, fifo_out;
  logic          mac_valid;

  // memories are frozen while reset is held so contents survive it
  sram_w32 #(.width(RW), .addr_w(addr_w)) u_qmem (
    .clk (clk),
    .cen (!(reset && (qmem_rd || qmem_wr))),
    .wen (!qmem_wr),
    .a   (qkmem_add),
    .d   (mem_in),
    .q   (qmem_q)
  );

  sram_w32 #(.width(RW), .addr_w(addr_w)) u_kmem (
    .clk (clk),
    .cen (!(reset && (kmem_rd || kmem_wr))),
    .wen (!kmem_wr),
    .a   (qkmem_add),
    .d   (mem_in),
    .q   (kmem_q)
  );

  assign mac_in = mode[0] ? kmem_q : qmem_q;

  mac_array #(
    .col(col), .bw(bw), .bw_psum(bw_psum), .pr(pr)
  ) u_mac (
    .in_row    (mac_in),
    .fire      (mode[1]),
    .out_lanes (mac_out),
    .valid     (mac_valid)
  );

  ofifo #(.width(PW), .depth_w(3)) u_ofifo (
    .clk  (clk),
    .rst  (rst),
    .push (mac_valid),
    .pop  (ofifo_rd),
    .din  (mac_out),
    .dout (fifo_out)
  );

  logic              acc_go, acc_wb;
  logic [addr_w-1:0] acc_addr;
  logic [PW-1:0]     acc_data, acc_sum;
  logic              norm_busy, norm_rd;
  logic [addr_w-1:0] norm_addr;
  logic              p_cen, p_wen;
  logic [addr_w-1:0] p_a;
  logic [PW-1:0]     p_d;

  assign busy   = acc_wb || norm_busy;
  assign acc_go = reset && pmem_wr && pmem_acc && !busy;

  for (genvar l = 0; l < col; l++) begin : g_lane
    logic signed [bw_psum-1:0] q_l, f_l;
    assign q_l = out[l*bw_psum +: bw_psum];
    assign f_l = acc_data[l*bw_psum +: bw_psum];
`ifdef ATTN_CORE_SAT_ACC_EN
    logic signed [32:0] s_l;
    assign s_l = 33'(q_l) + 33'(f_l);
    assign acc_sum[l*bw_psum +: bw_psum] =
      bw_psum'(lane_sat(s_l, bw_psum));
`else
    assign acc_sum[l*bw_psum +: bw_psum] = q_l + f_l;
`endif
  end

  attn_row_norm #(
    .col(col), .bw_psum(bw_psum),
    .sum_w(sum_w), .addr_w(addr_w)
  ) u_norm (
    .clk       (clk),
    .rst       (rst),
    .start     (sum_start && !busy),
    .stall     (acc_wb),
    .addr      (pmem_add),
    .psum      (out),
    .rd_en     (norm_rd),
    .rd_addr   (norm_addr),
    .busy      (norm_busy),
    .sum_valid (sum_valid),
    .sum_out   (sum_out)
  );

  // port priority: writeback, then norm read, then host
  always_comb begin
    p_cen = 1'b1;
    p_wen = 1'b1;
    p_a   = pmem_add;
    p_d   = fifo_out;
    if (!reset) begin
      p_cen = 1'b1;
    end else if (acc_wb) begin
      p_cen = 1'b0;
      p_wen = 1'b0;
      p_a   = acc_addr;
      p_d   = acc_sum;
    end else if (norm_rd) begin
      p_cen = 1'b0;
      p_a   = norm_addr;
    end else if (!busy && (pmem_rd || pmem_wr)) begin
      p_cen = 1'b0;
      p_wen = !(pmem_wr && !pmem_acc);
    end
  end

  sram_w32 #(.width(PW), .addr_w(addr_w)) u_pmem (
    .clk (clk),
    .cen (p_cen),
    .wen (p_wen),
    .a   (p_a),
    .d   (p_d),
    .q   (out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_wb        <= 1'b0;
      pmem_conflict <= 1'b0;
    end else begin
      acc_wb <= acc_go;
      if (busy && (pmem_rd || pmem_wr)) pmem_conflict <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_go) begin
      acc_addr <= pmem_add;
      acc_data <= fifo_out;
    end
  end

endmodule

// File: tb/tb_attn_core.sv
// tb_attn_core: directed table plus hand sequences for attn_core.
// Expected values are hand-computed lane constants.
module tb_attn_core;

  localparam int IW = 21;

  localparam logic [IW-1:0] PWR  = 21'h000001;
  localparam logic [IW-1:0] PRD  = 21'h000002;
  localparam logic [IW-1:0] QWR  = 21'h000010;
  localparam logic [IW-1:0] QRD  = 21'h000020;
  localparam logic [IW-1:0] FIRE = 21'h000080;
  localparam logic [IW-1:0] FRD  = 21'h040000;
  localparam logic [IW-1:0] ACC  = 21'h080000;
  localparam logic [IW-1:0] SST  = 21'h100000;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] inst;
  logic [127:0]  mem_in;
  logic [159:0]  out;
  logic [23:0]   sum_out;
  logic          sum_valid;
  logic          busy;
  logic          pmem_conflict;

  int errors = 0;
  int checks = 0;

  attn_core dut (
    .clk           (clk),
    .reset         (reset),
    .inst          (inst),
    .mem_in        (mem_in),
    .out           (out),
    .sum_out       (sum_out),
    .sum_valid     (sum_valid),
    .busy          (busy),
    .pmem_conflict (pmem_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int adr;
    bit acc;
    int a[8];
    int b[8];
    int e[8];
  } vec_t;

  vec_t tbl[3];

  function automatic logic [IW-1:0] pa(input int a);
    return IW'(a << 8);
  endfunction

  function automatic logic [127:0] pack_row(input int v[8]);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v[i][15:0];
    return r;
  endfunction

  function automatic logic [159:0] pack_exp(input int v[8]);
    logic [159:0] r;
    for (int i = 0; i < 8; i++) r[i*20 +: 20] = v[i][19:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [IW-1:0] v);
    inst = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int v[8]);
    mem_in = pack_row(v);
    tick(QWR);
    tick(QRD);
    tick(FIRE);
  endtask

  task automatic write_plain(input int a, input int v[8]);
    push_row(v);
    tick(PWR | FRD | pa(a));
  endtask

  task automatic accum(input int a, input int v[8]);
    push_row(v);
    tick(PWR | ACC | FRD | pa(a));
    tick('0);
  endtask

  task automatic read_chk(input string nm, input int a, input int e[8]);
    tick(PRD | pa(a));
    chk(nm, out, pack_exp(e));
  endtask

  initial begin
    int r[8];
    int e[8];

    tbl[0].adr = 3; tbl[0].acc = 1'b0;
    tbl[0].a = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[0].b = '{8{0}};
    tbl[0].e = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[1].adr = 5; tbl[1].acc = 1'b1;
    tbl[1].a = '{8{100}};
    tbl[1].b = '{8{-30}};
    tbl[1].e = '{8{70}};
    tbl[2].adr = 9; tbl[2].acc = 1'b1;
    tbl[2].a = '{-32768, 32767, -1, 0, 12345, -12345, 2, -2};
    tbl[2].b = '{-32768, 32767, 1, -1, 100, -100, -3, 3};
    tbl[2].e = '{-65536, 65534, 0, -1, 12445, -12445, -1, 1};

    reset  = 1'b0;
    inst   = '0;
    mem_in = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mem_in = {$urandom, $urandom, $urandom, $urandom};
      tick(IW'($urandom));
    end
    chk("rst_sum_out", sum_out, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conflict", pmem_conflict, 0);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      write_plain(tbl[i].adr, tbl[i].a);
      if (tbl[i].acc) begin
        push_row(tbl[i].b);
        tick(PWR | ACC | FRD | pa(tbl[i].adr));
        chk("acc_busy", busy, 1);
        tick('0);
        chk("acc_busy_drop", busy, 0);
      end
      read_chk("tbl_read", tbl[i].adr, tbl[i].e);
    end
    chk("tbl_conflict", pmem_conflict, 0);

    r = '{8{32767}};
    write_plain(2, r);
    for (int i = 0; i < 15; i++) accum(2, r);
    r = '{8{15}};
    accum(2, r);
    e = '{8{524287}};
    read_chk("wrap_pre", 2, e);
    r = '{8{1}};
    accum(2, r);
`ifdef ATTN_CORE_SAT_ACC_EN
    e = '{8{524287}};
`else
    e = '{8{-524288}};
`endif
    read_chk("wrap_edge", 2, e);

    r = '{-32768, 1, -2, 3, -4, 5, -6, 7};
    write_plain(7, r);
    r = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) accum(7, r);
    e = '{-524288, 1, -2, 3, -4, 5, -6, 7};
    read_chk("norm_row", 7, e);
    tick(SST | pa(7));
    chk("norm_busy_rd", busy, 1);
    chk("norm_valid_rd", sum_valid, 0);
    tick(SST | pa(3));
    chk("norm_busy_acc", busy, 1);
    chk("norm_valid_acc", sum_valid, 0);
    tick('0);
    chk("norm_valid", sum_valid, 1);
    chk("norm_sum", sum_out, 524316);
    chk("norm_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick('0);
      chk("norm_no_second", sum_valid, 0);
    end
    chk("norm_no_conflict", pmem_conflict, 0);

    r = '{8{5}};
    push_row(r);
    tick(PWR | ACC | FRD | pa(5));
    tick(PRD | pa(3));
    e = '{8{70}};
    chk("conf_read_dropped", out, pack_exp(e));
    chk("conf_flag", pmem_conflict, 1);
    tick('0);
    tick('0);
    chk("conf_sticky", pmem_conflict, 1);
    e = '{8{75}};
    read_chk("conf_acc_done", 5, e);

    push_row(r);
    tick(PWR | ACC | FRD | pa(5));
    reset = 1'b0;
    tick('0);
    reset = 1'b1;
    chk("rst_conf_clear", pmem_conflict, 0);
    chk("rst_acc_busy", busy, 0);
    read_chk("rst_acc_nowrite", 5, e);

    tick(SST | pa(7));
    reset = 1'b0;
    tick('0);
    chk("rst_norm_busy", busy, 0);
    chk("rst_norm_sum", sum_out, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick('0);
      chk("rst_norm_novalid", sum_valid, 0);
    end
    tick(SST | pa(7));
    tick('0);
    tick('0);
    chk("renorm_valid", sum_valid, 1);
    chk("renorm_sum", sum_out, 524316);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
